// File: rtl/frame_burst_ctrl_pkg.sv
// Shared definitions for the frame burst controller: channel FSM encoding,
// bus beat width and buffer address helper.
package frame_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } chan_state_t;

  localparam int unsigned BEAT_BYTES = 32;

  function automatic logic [31:0] buf_base_addr(input logic [31:0] base,
                                                 input logic [31:0] stride,
                                                 input logic        sel);
    return sel ? (base + stride) : base;
  endfunction

endpackage

// File: rtl/frame_burst_ctrl_if.sv
// Request/response and status signals between the frame burst controller
// and the AXI burst master / FIFO side.
interface frame_burst_ctrl_if;

  logic        WR_FRAME_SYNC;
  logic        RD_FRAME_SYNC;
  logic [9:0]  WR_FIFO_LEVEL;
  logic [9:0]  RD_FIFO_LEVEL;
  logic        WR_START;
  logic [31:0] WR_ADRS;
  logic [31:0] WR_LEN;
  logic        WR_DONE;
  logic        RD_START;
  logic [31:0] RD_ADRS;
  logic [31:0] RD_LEN;
  logic        RD_DONE;
  logic        MASTER_RST;

  modport master (
    input  WR_FRAME_SYNC, RD_FRAME_SYNC, WR_FIFO_LEVEL, RD_FIFO_LEVEL,
           WR_DONE, RD_DONE,
    output WR_START, WR_ADRS, WR_LEN, RD_START, RD_ADRS, RD_LEN, MASTER_RST
  );

  modport slave (
    output WR_FRAME_SYNC, RD_FRAME_SYNC, WR_FIFO_LEVEL, RD_FIFO_LEVEL,
           WR_DONE, RD_DONE,
    input  WR_START, WR_ADRS, WR_LEN, RD_START, RD_ADRS, RD_LEN, MASTER_RST
  );

endinterface

// File: rtl/frame_burst_ctrl_burst_chan.sv
// One burst channel: request FSM, frame address/byte counter and deferred
// frame-sync handling. The FIFO-level trigger is supplied by the parent.
module burst_chan
  import frame_burst_ctrl_pkg::*;
#(
  parameter int unsigned BURST_BYTES = 2048,
  parameter int unsigned FRAME_BYTES = 8294400,
  parameter logic [31:0] BUF_BASE    = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sync,
  input  logic        i_sync_buf,
  input  logic        i_level_ok,
  input  logic        i_done,
  output logic        o_start,
  output logic [31:0] o_adrs,
  output logic        o_buf,
  output logic        o_frame_done
);

  localparam logic [31:0] BURST_L = 32'(BURST_BYTES);
  localparam logic [31:0] FRAME_L = 32'(FRAME_BYTES);

  chan_state_t r_state;
  chan_state_t w_state_next;
  logic        r_buf;
  logic        r_armed;
  logic        r_pending;
  logic [31:0] r_addr;
  logic [31:0] r_count;
  logic [31:0] r_adrs;
  logic [31:0] w_count_acc;
  logic        w_fire;
  logic        w_apply_sync;

  assign w_count_acc  = r_count + BURST_L;
  assign w_fire       = r_armed && (r_count < FRAME_L) && i_level_ok;
  // A sync is taken at once in IDLE, otherwise held until DONE retires the burst.
  assign w_apply_sync = ((r_state == ST_IDLE) && i_sync) ||
                        ((r_state == ST_DONE) && (r_pending || i_sync));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!i_sync && w_fire) w_state_next = ST_REQ;
      ST_REQ:  w_state_next = ST_BUSY;
      ST_BUSY: if (i_done) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_start      = (r_state == ST_REQ);
    o_frame_done = (r_state == ST_DONE) && (w_count_acc == FRAME_L);
  end

  assign o_adrs = r_adrs;
  assign o_buf  = r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= 1'b0;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_addr    <= BUF_BASE;
      r_count   <= 32'd0;
      r_adrs    <= BUF_BASE;
    end else begin
      if (w_apply_sync)  r_pending <= 1'b0;
      else if (i_sync)   r_pending <= 1'b1;

      if (r_state == ST_DONE) begin
        r_addr  <= r_addr + BURST_L;
        r_count <= w_count_acc;
        if (w_count_acc == FRAME_L) r_armed <= 1'b0;
      end

      // Placed after the DONE accounting so a coincident sync wins.
      if (w_apply_sync) begin
        r_buf   <= i_sync_buf;
        r_addr  <= buf_base_addr(BUF_BASE, BUF_STRIDE, i_sync_buf);
        r_count <= 32'd0;
        r_armed <= 1'b1;
      end

      if ((r_state == ST_IDLE) && (w_state_next == ST_REQ)) r_adrs <= r_addr;
    end
  end

endmodule

// File: rtl/frame_burst_ctrl.sv
// Double-buffered frame burst controller: independent write and read burst
// channels, write/read buffer ping-pong and a one-cycle master reset pulse.
module frame_burst_ctrl
  import frame_burst_ctrl_pkg::*;
#(
  parameter int unsigned BURST_BYTES = 2048,
  parameter int unsigned FRAME_BYTES = 8294400,
  parameter logic [31:0] BUF_BASE    = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  frame_burst_ctrl_if.master bus
);

  localparam int unsigned BURST_BEATS  = BURST_BYTES / BEAT_BYTES;
  localparam logic [31:0] WR_MIN_LEVEL = 32'(BURST_BEATS);
  localparam logic [31:0] RD_MAX_LEVEL = 32'(FIFO_DEPTH - BURST_BEATS);

  // Channel index 0 is write, 1 is read.
  logic [1:0]  w_sync;
  logic [1:0]  w_sync_buf;
  logic [1:0]  w_level_ok;
  logic [1:0]  w_done;
  logic [1:0]  w_start;
  logic [1:0]  w_buf;
  logic [1:0]  w_frame_done;
  logic [31:0] w_adrs [2];
  logic        w_unused_rd;

  logic        r_done_buf;
  logic        r_init;
  logic        r_master_rst;

  assign w_sync        = {bus.RD_FRAME_SYNC, bus.WR_FRAME_SYNC};
  assign w_done        = {bus.RD_DONE, bus.WR_DONE};
  assign w_level_ok[0] = ({22'd0, bus.WR_FIFO_LEVEL} >= WR_MIN_LEVEL);
  assign w_level_ok[1] = ({22'd0, bus.RD_FIFO_LEVEL} <= RD_MAX_LEVEL);
  // Writer ping-pongs; reader always picks up the last completed frame.
  assign w_sync_buf    = {r_done_buf, ~w_buf[0]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      burst_chan #(
        .BURST_BYTES (BURST_BYTES),
        .FRAME_BYTES (FRAME_BYTES),
        .BUF_BASE    (BUF_BASE),
        .BUF_STRIDE  (BUF_STRIDE)
      ) u_chan (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .i_sync       (w_sync[gi]),
        .i_sync_buf   (w_sync_buf[gi]),
        .i_level_ok   (w_level_ok[gi]),
        .i_done       (w_done[gi]),
        .o_start      (w_start[gi]),
        .o_adrs       (w_adrs[gi]),
        .o_buf        (w_buf[gi]),
        .o_frame_done (w_frame_done[gi])
      );
    end
  endgenerate

  assign w_unused_rd = w_buf[1] ^ w_frame_done[1];

  assign bus.WR_START   = w_start[0];
  assign bus.WR_ADRS    = w_adrs[0];
  assign bus.WR_LEN     = 32'(BURST_BYTES);
  assign bus.RD_START   = w_start[1];
  assign bus.RD_ADRS    = w_adrs[1];
  assign bus.RD_LEN     = 32'(BURST_BYTES);
  assign bus.MASTER_RST = r_master_rst;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)             r_done_buf <= 1'b0;
    else if (w_frame_done[0]) r_done_buf <= w_buf[0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_init       <= 1'b0;
      r_master_rst <= 1'b0;
    end else begin
      r_init       <= 1'b1;
      r_master_rst <= ~r_init;
    end
  end

endmodule

// File: tb/tb_frame_burst_ctrl.sv
// Self-checking bench for frame_burst_ctrl: trigger-threshold vector table,
// address scoreboard fed at stimulus time, and multi-cycle corner sequences.
module tb_frame_burst_ctrl;

  localparam int unsigned BURST  = 256;
  localparam int unsigned FRAME  = 1024;
  localparam logic [31:0] STRIDE = 32'h1000;

  typedef struct {
    logic        is_rd;
    logic [9:0]  level;
    int          exp_starts;
    logic [31:0] exp_adrs;
  } vec_t;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  frame_burst_ctrl_if bus();

  frame_burst_ctrl #(
    .BURST_BYTES (BURST),
    .FRAME_BYTES (FRAME),
    .BUF_BASE    (32'h0000_0000),
    .BUF_STRIDE  (STRIDE),
    .FIFO_DEPTH  (512)
  ) dut (
    .ACLK    (clk),
    .ARESETN (arstn),
    .bus     (bus.master)
  );

  int          n_cmp     = 0;
  int          n_err     = 0;
  int          wr_starts = 0;
  int          rd_starts = 0;
  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];
  bit          wr_auto   = 1'b0;
  bit          rd_auto   = 1'b0;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: each observed start is matched against the next expected address.
  always @(negedge clk) begin
    if (arstn && bus.WR_START) begin
      wr_starts++;
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected_start: got adrs 0x%08h, need no start", bus.WR_ADRS);
      end else begin
        check("wr_adrs", bus.WR_ADRS, wr_q.pop_front());
        check("wr_len", bus.WR_LEN, 32'(BURST));
      end
      $display("wr burst start adrs=0x%08h len=%0d", bus.WR_ADRS, bus.WR_LEN);
    end
    if (arstn && bus.RD_START) begin
      rd_starts++;
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected_start: got adrs 0x%08h, need no start", bus.RD_ADRS);
      end else begin
        check("rd_adrs", bus.RD_ADRS, rd_q.pop_front());
        check("rd_len", bus.RD_LEN, 32'(BURST));
      end
      $display("rd burst start adrs=0x%08h len=%0d", bus.RD_ADRS, bus.RD_LEN);
    end
  end

  initial forever begin
    @(negedge clk);
    if (wr_auto && arstn && bus.WR_START) begin
      tick(4);
      bus.WR_DONE = 1'b1;
      tick(1);
      bus.WR_DONE = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rd_auto && arstn && bus.RD_START) begin
      tick(4);
      bus.RD_DONE = 1'b1;
      tick(1);
      bus.RD_DONE = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    wr_auto = 1'b0;
    rd_auto = 1'b0;
    arstn = 1'b0;
    bus.WR_FRAME_SYNC = 1'b0;
    bus.RD_FRAME_SYNC = 1'b0;
    bus.WR_DONE = 1'b0;
    bus.RD_DONE = 1'b0;
    bus.WR_FIFO_LEVEL = 10'd0;
    bus.RD_FIFO_LEVEL = 10'd1023;
    tick(2);
    arstn = 1'b1;
    tick(3);
  endtask

  task automatic pulse_sync(input bit wr, input bit rd);
    bus.WR_FRAME_SYNC = wr;
    bus.RD_FRAME_SYNC = rd;
    tick(1);
    bus.WR_FRAME_SYNC = 1'b0;
    bus.RD_FRAME_SYNC = 1'b0;
  endtask

  task automatic wait_starts(input string name, input bit is_rd, input int target, input int budget);
    int i = 0;
    while (((is_rd ? rd_starts : wr_starts) < target) && (i < budget)) begin
      tick(1);
      i++;
    end
    check(name, is_rd ? rd_starts : wr_starts, target);
  endtask

  task automatic check_master_rst_pulse(input string tag);
    tick(1);
    check({tag, "_master_rst_hi"}, {31'd0, bus.MASTER_RST}, 32'd1);
    tick(1);
    check({tag, "_master_rst_lo"}, {31'd0, bus.MASTER_RST}, 32'd0);
  endtask

  initial begin
    int base_w;
    int base_r;

    vecs[0] = '{1'b0, 10'd7,    0, 32'h0000_1000};
    vecs[1] = '{1'b0, 10'd8,    1, 32'h0000_1000};
    vecs[2] = '{1'b0, 10'd0,    0, 32'h0000_1000};
    vecs[3] = '{1'b0, 10'd64,   1, 32'h0000_1000};
    vecs[4] = '{1'b1, 10'd505,  0, 32'h0000_0000};
    vecs[5] = '{1'b1, 10'd504,  1, 32'h0000_0000};
    vecs[6] = '{1'b1, 10'd0,    1, 32'h0000_0000};
    vecs[7] = '{1'b1, 10'd512,  0, 32'h0000_0000};

    // Reset values, with FIFO levels that would otherwise trigger bursts.
    bus.WR_FRAME_SYNC = 1'b0;
    bus.RD_FRAME_SYNC = 1'b0;
    bus.WR_DONE = 1'b0;
    bus.RD_DONE = 1'b0;
    bus.WR_FIFO_LEVEL = 10'd8;
    bus.RD_FIFO_LEVEL = 10'd0;
    tick(2);
    check("rst_wr_start", {31'd0, bus.WR_START}, 32'd0);
    check("rst_rd_start", {31'd0, bus.RD_START}, 32'd0);
    check("rst_wr_adrs", bus.WR_ADRS, 32'h0);
    check("rst_rd_adrs", bus.RD_ADRS, 32'h0);
    check("rst_wr_len", bus.WR_LEN, 32'(BURST));
    check("rst_rd_len", bus.RD_LEN, 32'(BURST));
    check("rst_master_rst", {31'd0, bus.MASTER_RST}, 32'd0);
    arstn = 1'b1;
    check_master_rst_pulse("por");
    tick(20);
    check("no_start_before_sync_wr", wr_starts, 0);
    check("no_start_before_sync_rd", rd_starts, 0);

    // Trigger threshold table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wr_auto = 1'b1;
      rd_auto = 1'b1;
      base_w = wr_starts;
      base_r = rd_starts;
      if (vecs[i].exp_starts != 0) begin
        if (vecs[i].is_rd) rd_q.push_back(vecs[i].exp_adrs);
        else               wr_q.push_back(vecs[i].exp_adrs);
      end
      if (vecs[i].is_rd) bus.RD_FIFO_LEVEL = vecs[i].level;
      else               bus.WR_FIFO_LEVEL = vecs[i].level;
      pulse_sync(!vecs[i].is_rd, vecs[i].is_rd);
      tick(6);
      bus.WR_FIFO_LEVEL = 10'd0;
      bus.RD_FIFO_LEVEL = 10'd1023;
      tick(12);
      check($sformatf("vec%0d_starts", i),
            vecs[i].is_rd ? (rd_starts - base_r) : (wr_starts - base_w),
            vecs[i].exp_starts);
    end
    check("vec_wr_q_drained", wr_q.size(), 0);
    check("vec_rd_q_drained", rd_q.size(), 0);

    // Level 7 holds off the write; raising to 8 starts on the next cycle.
    do_reset();
    wr_auto = 1'b1;
    base_w = wr_starts;
    bus.WR_FIFO_LEVEL = 10'd7;
    pulse_sync(1'b1, 1'b0);
    tick(8);
    check("lvl7_no_start", wr_starts - base_w, 0);
    wr_q.push_back(32'h0000_1000);
    bus.WR_FIFO_LEVEL = 10'd8;
    tick(1);
    check("lvl8_start_next_cycle", {31'd0, bus.WR_START}, 32'd1);
    bus.WR_FIFO_LEVEL = 10'd0;
    tick(12);
    check("lvl_wr_q_drained", wr_q.size(), 0);

    // Full frame into buffer 1, then read it back with a FIFO-level stall.
    do_reset();
    wr_auto = 1'b1;
    rd_auto = 1'b1;
    base_w = wr_starts;
    base_r = rd_starts;
    for (int k = 0; k < 4; k++) wr_q.push_back(32'h0000_1000 + 32'(k * BURST));
    bus.WR_FIFO_LEVEL = 10'd8;
    pulse_sync(1'b1, 1'b0);
    wait_starts("frame_wr_starts", 1'b0, base_w + 4, 80);
    tick(20);
    check("frame_wr_no_more", wr_starts - base_w, 4);
    check("frame_wr_q_drained", wr_q.size(), 0);
    bus.RD_FIFO_LEVEL = 10'd505;
    pulse_sync(1'b0, 1'b1);
    tick(10);
    check("rd_stall_505", rd_starts - base_r, 0);
    for (int k = 0; k < 4; k++) rd_q.push_back(32'h0000_1000 + 32'(k * BURST));
    bus.RD_FIFO_LEVEL = 10'd504;
    wait_starts("frame_rd_starts", 1'b1, base_r + 4, 80);
    tick(20);
    check("frame_rd_no_more", rd_starts - base_r, 4);
    check("frame_rd_q_drained", rd_q.size(), 0);

    // Two syncs during BUSY: deferred, absorbed, and the cut frame leaves done_buf alone.
    do_reset();
    base_w = wr_starts;
    base_r = rd_starts;
    wr_q.push_back(32'h0000_1000);
    bus.WR_FIFO_LEVEL = 10'd8;
    pulse_sync(1'b1, 1'b0);
    wait_starts("defer_first_start", 1'b0, base_w + 1, 10);
    tick(2);
    pulse_sync(1'b1, 1'b0);
    tick(1);
    pulse_sync(1'b1, 1'b0);
    tick(5);
    check("defer_adrs_held", bus.WR_ADRS, 32'h0000_1000);
    check("defer_no_start_in_busy", wr_starts - base_w, 1);
    wr_q.push_back(32'h0000_0000);
    bus.WR_DONE = 1'b1;
    tick(1);
    bus.WR_DONE = 1'b0;
    wait_starts("defer_new_base_start", 1'b0, base_w + 2, 10);
    bus.WR_FIFO_LEVEL = 10'd0;
    tick(2);
    bus.WR_DONE = 1'b1;
    tick(1);
    bus.WR_DONE = 1'b0;
    tick(6);
    check("defer_no_more", wr_starts - base_w, 2);
    rd_auto = 1'b1;
    rd_q.push_back(32'h0000_0000);
    bus.RD_FIFO_LEVEL = 10'd0;
    pulse_sync(1'b0, 1'b1);
    wait_starts("defer_rd_done_buf0", 1'b1, base_r + 1, 10);
    bus.RD_FIFO_LEVEL = 10'd1023;
    tick(12);
    check("defer_q_drained", wr_q.size() + rd_q.size(), 0);

    // Asynchronous reset with both channels mid-burst.
    do_reset();
    base_w = wr_starts;
    base_r = rd_starts;
    wr_q.push_back(32'h0000_1000);
    rd_q.push_back(32'h0000_0000);
    bus.WR_FIFO_LEVEL = 10'd8;
    bus.RD_FIFO_LEVEL = 10'd0;
    pulse_sync(1'b1, 1'b1);
    wait_starts("arst_wr_start", 1'b0, base_w + 1, 10);
    wait_starts("arst_rd_start", 1'b1, base_r + 1, 10);
    tick(2);
    #2;
    arstn = 1'b0;
    #1;
    check("arst_wr_start_low", {31'd0, bus.WR_START}, 32'd0);
    check("arst_rd_start_low", {31'd0, bus.RD_START}, 32'd0);
    check("arst_wr_adrs", bus.WR_ADRS, 32'h0);
    check("arst_rd_adrs", bus.RD_ADRS, 32'h0);
    check("arst_master_rst", {31'd0, bus.MASTER_RST}, 32'd0);
    tick(2);
    arstn = 1'b1;
    check_master_rst_pulse("arst");
    tick(20);
    check("arst_no_wr_start", wr_starts - base_w, 1);
    check("arst_no_rd_start", rd_starts - base_r, 1);
    wr_q.push_back(32'h0000_1000);
    pulse_sync(1'b1, 1'b0);
    wait_starts("arst_resync_start", 1'b0, base_w + 2, 10);
    bus.WR_FIFO_LEVEL = 10'd0;
    tick(3);
    check("arst_q_drained", wr_q.size() + rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
